// File: rtl/seq_sub_param_pkg.sv
// Shared ALU definitions for the sequential subtractor: state encoding and default width.
// Optional flag outputs of seq_sub_param are enabled with the SUB_FLAGS_EN macro.
package seq_sub_param_pkg;

    localparam int ALU_N = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_sub_param_sub_chunk.sv
// Combinational CHUNK-bit subtract slice: d = x - y - bin, built as x + ~y + ~bin
// from full-adder cells; bout is the inverted carry-out.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);
    logic [CHUNK:0] c_s;

    assign c_s[0] = ~bin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fa_cell u_fa (
            .x  (x[i]),
            .y  (~y[i]),
            .ci (c_s[i]),
            .s  (d[i]),
            .co (c_s[i+1])
        );
    end

    assign bout = ~c_s[CHUNK];
endmodule

// File: rtl/seq_sub_param.sv
// Multi-cycle signed subtractor diff = a - b - b_in, CHUNK bits per clock, LSB chunk first.
// Define SUB_FLAGS_EN to add the zero/neg/ovf status outputs.
module seq_sub_param
    import seq_sub_param_pkg::*;
#(
    parameter int N     = ALU_N,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         b_out
`ifdef SUB_FLAGS_EN
    ,
    output logic         zero,
    output logic         neg,
    output logic         ovf
`endif
);
    localparam int NCH = N / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

    state_t         state_r;
    state_t         state_nxt_s;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [CW-1:0]  cnt_r;
    logic           borrow_r;
    logic           accept_s;
    logic           last_s;
    logic [N-1:0]   diff_nxt_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] d_s;
    logic           bout_s;

    assign a_chunk_s = a_r[int'(cnt_r) * CHUNK +: CHUNK];
    assign b_chunk_s = b_r[int'(cnt_r) * CHUNK +: CHUNK];

    sub_chunk #(.CHUNK(CHUNK)) u_slice (
        .x    (a_chunk_s),
        .y    (b_chunk_s),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // Next-state decode, start acceptance and the result with the current chunk merged in
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = (cnt_r == LAST_CNT);
        diff_nxt_s  = diff;
        diff_nxt_s[int'(cnt_r) * CHUNK +: CHUNK] = d_s;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, operand, borrow-chain and registered result/handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            cnt_r    <= '0;
            borrow_r <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            b_out    <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero     <= 1'b0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                a_r      <= a;
                b_r      <= b;
                cnt_r    <= '0;
                borrow_r <= b_in;
                done     <= 1'b0;
                busy     <= 1'b1;
`ifdef SUB_FLAGS_EN
                zero     <= 1'b0;
                neg      <= 1'b0;
                ovf      <= 1'b0;
`endif
            end else if (state_r == ST_RUN) begin
                diff     <= diff_nxt_s;
                borrow_r <= bout_s;
                cnt_r    <= cnt_r + CW'(1);
                if (last_s) begin
                    b_out <= bout_s;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef SUB_FLAGS_EN
                    zero  <= (diff_nxt_s == '0);
                    neg   <= diff_nxt_s[N-1];
                    ovf   <= (a_r[N-1] != b_r[N-1]) && (diff_nxt_s[N-1] != a_r[N-1]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_sub_param.sv
// Self-checking bench for seq_sub_param: directed handshake/arithmetic cases on CHUNK=8
// and a randomized sweep over CHUNK = 8, 1, 4, 32 against an arithmetic reference model.
module tb_seq_sub_param;
    localparam int N  = 32;
    localparam int ND = 4;
    localparam int CH [ND] = '{8, 1, 4, 32};

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          b_in;
    logic          busy_o  [ND];
    logic          done_o  [ND];
    logic [N-1:0]  diff_o  [ND];
    logic          b_out_o [ND];
`ifdef SUB_FLAGS_EN
    logic          zero_o  [ND];
    logic          neg_o   [ND];
    logic          ovf_o   [ND];
`endif

    int checks;
    int failures;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        seq_sub_param #(.N(N), .CHUNK(CH[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .a     (a),
            .b     (b),
            .b_in  (b_in),
            .busy  (busy_o[g]),
            .done  (done_o[g]),
            .diff  (diff_o[g]),
            .b_out (b_out_o[g])
`ifdef SUB_FLAGS_EN
            ,
            .zero  (zero_o[g]),
            .neg   (neg_o[g]),
            .ovf   (ovf_o[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high across exactly one active edge
    task automatic pulse_start(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi);
        a     = av;
        b     = bv;
        b_in  = bi;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        b_in  = 1'($urandom);
    endtask

    // Wait (bounded) for done of instance 0; lat = edges after acceptance
    task automatic wait_done0(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (done_o[0]) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) check_eq("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input string tag, input int g, input logic [N-1:0] av,
                                input logic [N-1:0] bv, input logic bi);
        longint unsigned ua, ub;
        longint          sa, sb, sres;
        logic [N-1:0]    exp_diff;
        ua = longint'(av);
        ub = longint'(bv);
        exp_diff = N'((ua - ub - longint'(bi)) & 64'hFFFF_FFFF);
        check_eq({tag, "_diff"}, 64'(diff_o[g]), 64'(exp_diff));
        check_eq({tag, "_bout"}, 64'(b_out_o[g]), 64'(ua < ub + longint'(bi)));
`ifdef SUB_FLAGS_EN
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        sres = sa - sb - longint'(bi);
        check_eq({tag, "_zero"}, 64'(zero_o[g]), 64'(exp_diff == '0));
        check_eq({tag, "_neg"},  64'(neg_o[g]),  64'(sres < 0 ? (sres >= -64'sd2147483648) : (sres > 64'sd2147483647)));
        check_eq({tag, "_ovf"},  64'(ovf_o[g]),  64'((sres > 64'sd2147483647) || (sres < -64'sd2147483648)));
`else
        sa = 0; sb = 0; sres = 0;
`endif
    endtask

    int lat;
    int lats [ND];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        b_in = 1'b0;
        #12;
        check_eq("rst_busy", 64'(busy_o[0]), 64'd0);
        check_eq("rst_done", 64'(done_o[0]), 64'd0);
        check_eq("rst_diff", 64'(diff_o[0]), 64'd0);
        check_eq("rst_bout", 64'(b_out_o[0]), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("idle_busy", 64'(busy_o[0]), 64'd0);

        // Basic subtract with busy window
        pulse_start(32'd100, 32'd58, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq("basic_busy", 64'(busy_o[0]), 64'd1);
            check_eq("basic_notdone", 64'(done_o[0]), 64'd0);
            step();
        end
        check_eq("basic_done", 64'(done_o[0]), 64'd1);
        check_eq("basic_busy_end", 64'(busy_o[0]), 64'd0);
        check_result("basic", 0, 32'd100, 32'd58, 1'b0);

        // Borrow through every chunk
        pulse_start(32'd0, 32'd1, 1'b0);
        wait_done0(lat);
        check_result("borrow", 0, 32'd0, 32'd1, 1'b0);
        check_eq("borrow_diff_k", 64'(diff_o[0]), 64'hFFFF_FFFF);

        // Signed overflow, with and without borrow-in
        pulse_start(32'h8000_0000, 32'd1, 1'b0);
        wait_done0(lat);
        check_eq("ovf_diff_k", 64'(diff_o[0]), 64'h7FFF_FFFF);
        check_result("ovf0", 0, 32'h8000_0000, 32'd1, 1'b0);
        pulse_start(32'h8000_0000, 32'd1, 1'b1);
        wait_done0(lat);
        check_eq("ovf1_diff_k", 64'(diff_o[0]), 64'h7FFF_FFFE);
        check_result("ovf1", 0, 32'h8000_0000, 32'd1, 1'b1);

        // start while busy is ignored
        pulse_start(32'd100, 32'd58, 1'b0);
        pulse_start(32'd5, 32'd3, 1'b0);
        wait_done0(lat);
        check_eq("ign_lat", 64'(lat + 1), 64'd4);
        check_eq("ign_diff", 64'(diff_o[0]), 64'd42);

        // start accepted from DONE
        pulse_start(32'd5, 32'd3, 1'b0);
        check_eq("redo_done_drop", 64'(done_o[0]), 64'd0);
        check_eq("redo_busy", 64'(busy_o[0]), 64'd1);
        wait_done0(lat);
        check_eq("redo_lat", 64'(lat), 64'd4);
        check_eq("redo_diff", 64'(diff_o[0]), 64'd2);

        // Asynchronous reset in the middle of RUN
        pulse_start(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_busy", 64'(busy_o[0]), 64'd0);
        check_eq("mrst_done", 64'(done_o[0]), 64'd0);
        check_eq("mrst_diff", 64'(diff_o[0]), 64'd0);
        check_eq("mrst_bout", 64'(b_out_o[0]), 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("post_rst_busy", 64'(busy_o[0]), 64'd0);
            check_eq("post_rst_done", 64'(done_o[0]), 64'd0);
        end

        // Randomized sweep across all chunk widths
        for (int it = 0; it < 1000; it++) begin
            logic [N-1:0] ra, rb;
            logic         rbi;
            bit           all_done;
            ra  = $urandom;
            rb  = $urandom;
            rbi = 1'($urandom);
            case (it % 16)
                0: ra = rb;
                1: rb = '0;
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            pulse_start(ra, rb, rbi);
            for (int g = 0; g < ND; g++) lats[g] = 0;
            for (int c = 1; c <= 40; c++) begin
                step();
                all_done = 1'b1;
                for (int g = 0; g < ND; g++) begin
                    if (done_o[g] && lats[g] == 0) lats[g] = c;
                    if (lats[g] == 0) all_done = 1'b0;
                end
                if (all_done) break;
            end
            for (int g = 0; g < ND; g++) begin
                check_eq($sformatf("rnd_lat_c%0d", CH[g]), 64'(lats[g]), 64'(N / CH[g]));
                check_result($sformatf("rnd_c%0d", CH[g]), g, ra, rb, rbi);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
